// File: rtl/risc8_com_pkg.sv
// Shared definitions for the risc8 com-bus UART: register offsets, STATUS bit
// positions and the engine state type used by both serial engines.
package risc8_com_pkg;

    localparam logic [7:0] COM_TXDATA   = 8'd0;
    localparam logic [7:0] COM_RXDATA   = 8'd1;
    localparam logic [7:0] COM_STATUS   = 8'd2;
    localparam logic [7:0] COM_IRQEN_WR = 8'd3;
    localparam logic [7:0] COM_IRQEN_RD = 8'd4;

    localparam int ST_RX_NEMPTY = 0;
    localparam int ST_RX_FULL   = 1;
    localparam int ST_TX_EMPTY  = 2;
    localparam int ST_TX_FULL   = 3;
    localparam int ST_TX_BUSY   = 4;
    localparam int ST_RX_OVF    = 5;
    localparam int ST_TX_OVF    = 6;
    localparam int ST_FRM_ERR   = 7;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/com_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty; push and pop in
// the same cycle are both honoured, including when full.
module com_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/risc8_com_uart.sv
// Memory-mapped 8N1 UART on the risc8 com bus: TX/RX FIFOs, serial engines,
// sticky error flags and a level interrupt.
module risc8_com_uart
    import risc8_com_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'h10,
    parameter int         CLK_DIV    = 434,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] com_addr,
    input  logic [7:0] com_wr,
    output logic [7:0] com_rd,
    output logic       com_interrupt,
    output logic       uart_tx,
    input  logic       uart_rx
);

    localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

    logic [7:0] offset;
    logic       hit;
    logic       wr_txdata;
    logic       rd_rxdata;
    logic       rd_status;
    logic       wr_irqen;

    logic [7:0] tx_head;
    logic       tx_empty;
    logic       tx_full;
    logic       tx_pop;
    logic [7:0] rx_head;
    logic       rx_empty;
    logic       rx_full;
    logic       rx_push;

    logic       rx_ovf;
    logic       tx_ovf;
    logic       frm_err;
    logic       frm_err_set;
    logic [1:0] irq_en;
    logic [7:0] status;

    uart_state_t tx_state, tx_state_next;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_last;
    logic        tx_busy;

    uart_state_t rx_state, rx_state_next;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_sync1;
    logic        rx_sync2;
    logic        rx_prev;
    logic        rx_wait_high;
    logic        rx_sample;
    logic        rx_half;
    logic        rx_fall;

    assign offset    = com_addr - BASE_ADDR;
    assign hit       = (com_addr >= BASE_ADDR) && (offset <= COM_IRQEN_RD);
    assign wr_txdata = hit && (offset == COM_TXDATA);
    assign rd_rxdata = hit && (offset == COM_RXDATA);
    assign rd_status = hit && (offset == COM_STATUS);
    assign wr_irqen  = hit && (offset == COM_IRQEN_WR);

    com_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_txdata),
        .push_data (com_wr),
        .pop       (tx_pop),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (tx_full)
    );

    com_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rd_rxdata),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full)
    );

    assign tx_busy = (tx_state != IDLE);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        status               = '0;
        status[ST_RX_NEMPTY] = !rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_BUSY]   = tx_busy;
        status[ST_RX_OVF]    = rx_ovf;
        status[ST_TX_OVF]    = tx_ovf;
        status[ST_FRM_ERR]   = frm_err;
    end

    // Out-of-range reads drive zero so several peripherals can be OR-ed onto the bus.
    always_comb begin
        com_rd = 8'h00;
        if (hit) begin
            case (offset)
                COM_RXDATA:   com_rd = rx_empty ? 8'h00 : rx_head;
                COM_STATUS:   com_rd = status;
                COM_IRQEN_RD: com_rd = {6'b0, irq_en};
                default:      com_rd = 8'h00;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as a STATUS read wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ovf        <= 1'b0;
            tx_ovf        <= 1'b0;
            frm_err       <= 1'b0;
            irq_en        <= 2'b00;
            com_interrupt <= 1'b0;
        end else begin
            if (rx_push && rx_full && !rd_rxdata) rx_ovf <= 1'b1;
            else if (rd_status)                   rx_ovf <= 1'b0;
            if (wr_txdata && tx_full && !tx_pop)  tx_ovf <= 1'b1;
            else if (rd_status)                   tx_ovf <= 1'b0;
            if (frm_err_set)                      frm_err <= 1'b1;
            else if (rd_status)                   frm_err <= 1'b0;
            if (wr_irqen) irq_en <= com_wr[1:0];
            com_interrupt <= (irq_en[0] & !rx_empty) | (irq_en[1] & tx_empty & !tx_busy);
        end
    end

    assign tx_last = (tx_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= IDLE;
        else      tx_state <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_pop        = 1'b0;
        case (tx_state)
            IDLE: if (!tx_empty) begin
                tx_pop        = 1'b1;
                tx_state_next = START;
            end
            START: if (tx_last) tx_state_next = DATA;
            DATA:  if (tx_last && tx_bit == 3'd7) tx_state_next = STOP;
            STOP: if (tx_last) begin
                if (!tx_empty) begin
                    tx_pop        = 1'b1;
                    tx_state_next = START;
                end else begin
                    tx_state_next = IDLE;
                end
            end
            default: tx_state_next = IDLE;
        endcase
    end

    // uart_tx is a flop with async set, so reset forces the line idle immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else if (tx_pop) begin
            tx_shift <= tx_head;
            tx_cnt   <= '0;
            uart_tx  <= 1'b0;
        end else if (tx_state != IDLE) begin
            if (tx_last) begin
                tx_cnt <= '0;
                case (tx_state)
                    START: begin
                        uart_tx  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= '0;
                    end
                    DATA: begin
                        if (tx_bit == 3'd7) begin
                            uart_tx <= 1'b1;
                        end else begin
                            uart_tx  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end
                    default: uart_tx <= 1'b1;
                endcase
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            rx_sync1 <= uart_rx;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
        end
    end

    assign rx_fall   = rx_prev && !rx_sync2;
    assign rx_half   = (rx_cnt == HALF_LAST);
    assign rx_sample = (rx_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= IDLE;
        else      rx_state <= rx_state_next;
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_push       = 1'b0;
        frm_err_set   = 1'b0;
        case (rx_state)
            IDLE:  if (rx_fall) rx_state_next = START;
            START: if (rx_half) rx_state_next = rx_sync2 ? IDLE : DATA;
            DATA:  if (rx_sample && rx_bit == 3'd7) rx_state_next = STOP;
            STOP: begin
                if (rx_wait_high) begin
                    if (rx_sync2) rx_state_next = IDLE;
                end else if (rx_sample) begin
                    if (rx_sync2) begin
                        rx_push       = 1'b1;
                        rx_state_next = IDLE;
                    end else begin
                        frm_err_set = 1'b1;
                    end
                end
            end
            default: rx_state_next = IDLE;
        endcase
    end

    // After a low stop bit the engine parks in STOP until the line returns high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_wait_high <= 1'b0;
        end else begin
            case (rx_state)
                IDLE: begin
                    rx_cnt       <= '0;
                    rx_wait_high <= 1'b0;
                end
                START: begin
                    rx_bit <= '0;
                    rx_cnt <= rx_half ? 16'd0 : rx_cnt + 16'd1;
                end
                DATA: begin
                    if (rx_sample) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (!rx_wait_high) begin
                        if (rx_sample) begin
                            rx_cnt <= '0;
                            if (!rx_sync2) rx_wait_high <= 1'b1;
                        end else begin
                            rx_cnt <= rx_cnt + 16'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc8_com_uart.sv
// Self-checking bench for risc8_com_uart: randomised TX bursts and RX frames
// compared against a queue-based model of the register map and 8N1 framing.
module tb_risc8_com_uart;

    localparam int         CLK_DIV = 4;
    localparam int         DEPTH   = 8;
    localparam logic [7:0] A_TX    = 8'h10;
    localparam logic [7:0] A_RX    = 8'h11;
    localparam logic [7:0] A_ST    = 8'h12;
    localparam logic [7:0] A_IEW   = 8'h13;
    localparam logic [7:0] A_IER   = 8'h14;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] com_addr = 8'h00;
    logic [7:0] com_wr = 8'h00;
    logic [7:0] com_rd;
    logic       com_interrupt;
    logic       uart_tx;
    logic       uart_rx = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_exp [$];
    logic [7:0] tx_seen [$];
    logic [7:0] rx_model [$];

    always #5 clk = ~clk;

    risc8_com_uart #(.BASE_ADDR(8'h10), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .com_addr      (com_addr),
        .com_wr        (com_wr),
        .com_rd        (com_rd),
        .com_interrupt (com_interrupt),
        .uart_tx       (uart_tx),
        .uart_rx       (uart_rx)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected STATUS byte assembled from named flags in register bit order.
    function automatic int st(input logic rx_ne, input logic rx_fu, input logic tx_em,
                              input logic tx_fu, input logic busy, input logic rx_ov,
                              input logic tx_ov, input logic frm);
        return int'({frm, tx_ov, rx_ov, busy, tx_fu, tx_em, rx_fu, rx_ne});
    endfunction

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus cycle; entered and left just after a rising edge.
    task automatic bus(input logic [7:0] a, input logic [7:0] d,
                       output logic [7:0] r, output logic irq);
        com_addr = a;
        com_wr   = d;
        @(negedge clk);
        r   = com_rd;
        irq = com_interrupt;
        @(posedge clk);
        #1;
        com_addr = 8'h00;
        com_wr   = 8'h00;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r;
        logic       i;
        bus(a, d, r, i);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] r);
        logic i;
        bus(a, 8'h00, r, i);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        hold(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            hold(CLK_DIV);
        end
        uart_rx = stop_bit;
        hold(CLK_DIV);
        if (!stop_bit) begin
            uart_rx = 1'b0;
            hold(2 * CLK_DIV);
        end
        uart_rx = 1'b1;
    endtask

    task automatic wait_tx_idle();
        logic [7:0] r;
        logic       i;
        int         n = 0;
        do begin
            bus(A_ST, 8'h00, r, i);
            n++;
        end while ((r[4] || !r[2]) && n < 2000);
        check("tx_idle_timeout", int'(n < 2000), 1);
        hold(2);
        check("tx_frame_count", tx_seen.size(), tx_exp.size());
        while (tx_exp.size() > 0 && tx_seen.size() > 0)
            check("tx_frame_byte", int'(tx_seen.pop_front()), int'(tx_exp.pop_front()));
        tx_exp.delete();
        tx_seen.delete();
    endtask

    // Writes n bytes on consecutive cycles into an idle transmitter: one goes
    // straight to the engine, DEPTH fit in the FIFO, the rest are dropped.
    task automatic burst(input int n);
        logic [7:0] b;
        logic [7:0] r;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            wr(A_TX, b);
            if (i < DEPTH + 1) tx_exp.push_back(b);
        end
        hold(1);
        rd(A_ST, r);
        check("burst_status", int'(r),
              st(1'b0, 1'b0, n == 1, n >= DEPTH + 1, 1'b1, 1'b0, n >= DEPTH + 2, 1'b0));
        rd(A_ST, r);
        check("burst_status_clr", int'(r),
              st(1'b0, 1'b0, n == 1, n >= DEPTH + 1, 1'b1, 1'b0, 1'b0, 1'b0));
        wait_tx_idle();
    endtask

    // Frame decoder on uart_tx, sampling mid-bit.
    initial begin
        int         mon_cnt = 0;
        logic       mon_active = 1'b0;
        logic [7:0] mon_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (!uart_tx) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt % CLK_DIV == CLK_DIV / 2) begin
                    if (mon_cnt / CLK_DIV == 0) begin
                        check("tx_start_bit", int'(uart_tx), 0);
                    end else if (mon_cnt / CLK_DIV <= 8) begin
                        mon_byte = {uart_tx, mon_byte[7:1]};
                    end else begin
                        check("tx_stop_bit", int'(uart_tx), 1);
                        tx_seen.push_back(mon_byte);
                        mon_active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        logic       irq;
        logic [7:0] b;
        logic [9:0] frame;
        logic       found;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state and address decoding boundaries
        @(negedge clk);
        check("rst_uart_tx", int'(uart_tx), 1);
        check("rst_irq", int'(com_interrupt), 0);
        @(posedge clk);
        #1;
        rd(A_ST, r);
        check("rst_status", int'(r), 'h04);
        rd(A_IER, r);
        check("rst_irqen", int'(r), 'h00);
        rd(A_RX, r);
        check("rst_rxdata", int'(r), 'h00);
        rd(8'h0F, r);
        check("below_range", int'(r), 'h00);
        wr(8'h15, 8'h5A);
        rd(8'h15, r);
        check("above_range", int'(r), 'h00);
        rd(A_ST, r);
        check("above_range_no_push", int'(r), 'h04);

        // Single frame, bit-exact waveform
        wr(A_TX, 8'hA5);
        tx_exp.push_back(8'hA5);
        @(negedge clk);
        check("tx_before_start", int'(uart_tx), 1);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10 * CLK_DIV; k++) begin
            @(negedge clk);
            check("tx_wave", int'(uart_tx), int'(frame[k / CLK_DIV]));
        end
        @(posedge clk);
        #1;
        rd(A_ST, r);
        check("tx_done_status", int'(r), 'h04);
        wait_tx_idle();

        // TX bursts around the overflow boundary, then random sizes
        burst(DEPTH + 1);
        burst(DEPTH + 2);
        for (int t = 0; t < 3; t++) burst(int'($urandom_range(12, 2)));

        // RX directed and random frames
        send_frame(8'h3C, 1'b1);
        hold(4);
        rd(A_ST, r);
        check("rx_status", int'(r), 'h05);
        rd(A_RX, r);
        check("rx_data", int'(r), 'h3C);
        rd(A_RX, r);
        check("rx_empty_read", int'(r), 'h00);
        for (int t = 0; t < 4; t++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            hold(4);
            rd(A_RX, r);
            check("rx_rand", int'(r), int'(b));
        end
        rd(A_ST, r);
        check("rx_drained", int'(r), 'h04);

        // Framing error, then a one-cycle glitch
        send_frame(8'($urandom), 1'b0);
        hold(4);
        rd(A_ST, r);
        check("frm_err_status", int'(r), 'h84);
        rd(A_ST, r);
        check("frm_err_clr", int'(r), 'h04);
        uart_rx = 1'b0;
        hold(1);
        uart_rx = 1'b1;
        hold(3 * CLK_DIV);
        rd(A_ST, r);
        check("glitch_status", int'(r), 'h04);

        // RX overflow: DEPTH+1 frames without reading
        for (int t = 0; t <= DEPTH; t++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            hold(4);
            if (t < DEPTH) rx_model.push_back(b);
        end
        rd(A_ST, r);
        check("rx_ovf_status", int'(r), 'h27);
        rd(A_ST, r);
        check("rx_ovf_clr", int'(r), 'h07);
        while (rx_model.size() > 0) begin
            rd(A_RX, r);
            check("rx_fifo_order", int'(r), int'(rx_model.pop_front()));
        end
        rd(A_RX, r);
        check("rx_after_drain", int'(r), 'h00);

        // rx_nempty interrupt: rises one cycle after data, falls one cycle after empty
        wr(A_IEW, 8'h01);
        bus(A_IER, 8'h00, r, irq);
        check("irqen_read", int'(r), 'h01);
        check("irq_idle", int'(irq), 0);
        b = 8'($urandom);
        send_frame(b, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            bus(A_ST, 8'h00, r, irq);
            if (r[0]) begin
                found = 1'b1;
                check("irq_lag", int'(irq), 0);
            end
        end
        check("rx_arrival", int'(found), 1);
        bus(A_IER, 8'h00, r, irq);
        check("irq_raised", int'(irq), 1);
        bus(A_RX, 8'h00, r, irq);
        check("irq_rx_data", int'(r), int'(b));
        check("irq_at_pop", int'(irq), 1);
        bus(A_ST, 8'h00, r, irq);
        check("irq_after_empty", int'(irq), 1);
        bus(A_ST, 8'h00, r, irq);
        check("irq_dropped", int'(irq), 0);

        // tx_idle interrupt
        wr(A_IEW, 8'h02);
        bus(A_ST, 8'h00, r, irq);
        check("txirq_lag", int'(irq), 0);
        bus(A_ST, 8'h00, r, irq);
        check("txirq_raised", int'(irq), 1);
        b = 8'($urandom);
        bus(A_TX, b, r, irq);
        tx_exp.push_back(b);
        bus(A_ST, 8'h00, r, irq);
        check("txirq_hold", int'(irq), 1);
        bus(A_ST, 8'h00, r, irq);
        check("txirq_drop", int'(irq), 0);
        wr(A_IEW, 8'h00);
        wait_tx_idle();

        // Reset mid-frame returns uart_tx high without a clock edge
        wr(A_TX, 8'h00);
        hold(6);
        #2;
        check("tx_mid_frame_low", int'(uart_tx), 0);
        rst = 1'b0;
        #1;
        check("tx_async_reset", int'(uart_tx), 1);
        hold(2);
        rst = 1'b1;
        hold(2);
        rd(A_ST, r);
        check("post_reset_status", int'(r), 'h04);
        hold(12 * CLK_DIV);
        check("post_reset_no_frame", tx_seen.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
